// File: rtl/credit_tx_gate.sv
// ---------------------------------------------------------------------------
// credit_tx_gate
//
// Transmit-side credit gate for a credit-flow link. The far end returns
// credits in batches. Upstream beats are forwarded only while the local
// credit count is non-zero, and each forwarded beat consumes one credit.
// Forwarded beats leave through a single output register (latency 1) toward
// a downstream link that has no ready signal.
//
// Ports:
//   CLK        clock; all state updates on posedge
//   RST        synchronous, active-high reset
//   IN_VALID   upstream beat offered
//   IN_DATA    upstream beat data            [dwidth-1:0]
//   IN_READY   gate can accept a beat this cycle
//   OUT_VALID  registered beat valid to the link
//   OUT_DATA   registered beat data to the link [dwidth-1:0]
//   RET_VALID  credit return strobe
//   RET_COUNT  number of credits returned, 0 legal [width-1:0]
//   SETC       force the credit count
//   DATA_C     value loaded by SETC            [width-1:0]
//   CLR_OVF    clear the sticky overflow flag
//   CREDITS    current credit count            [width-1:0]
//   LOW        CREDITS <= low_water
//   OVERFLOW   sticky: a load or return would have exceeded max_credits
// ---------------------------------------------------------------------------
module credit_tx_gate #(
    parameter int width        = 4,
    parameter int dwidth       = 8,
    parameter int init_credits = 4,
    parameter int max_credits  = 15,
    parameter int low_water    = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              IN_VALID,
    input  logic [dwidth-1:0] IN_DATA,
    output logic              IN_READY,
    output logic              OUT_VALID,
    output logic [dwidth-1:0] OUT_DATA,
    input  logic              RET_VALID,
    input  logic [width-1:0]  RET_COUNT,
    input  logic              SETC,
    input  logic [width-1:0]  DATA_C,
    input  logic              CLR_OVF,
    output logic [width-1:0]  CREDITS,
    output logic              LOW,
    output logic              OVERFLOW
);

    localparam logic [width-1:0] INIT_C = width'(init_credits);
    localparam logic [width-1:0] MAX_C  = width'(max_credits);
    localparam logic [width:0]   MAX_W  = (width + 1)'(max_credits);
    localparam logic [width-1:0] LOW_C  = width'(low_water);

    logic [width-1:0] credits_q;
    logic [width-1:0] credits_nxt;
    logic             ovf_set;
    logic             accept;
    logic [width:0]   ret_ext;
    logic [width:0]   sum;

    // A return arriving while credits are zero is not usable until it has
    // landed in the register, so readiness looks only at the stored count.
    assign IN_READY = !RST && !SETC && (credits_q != '0);
    assign accept   = IN_VALID && IN_READY;
    assign CREDITS  = credits_q;
    assign LOW      = (credits_q <= LOW_C);

    // Credit next-state is computed one bit wider than the counter so that
    // a return that would exceed the ceiling is detected rather than wrapped.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        credits_nxt = credits_q;
        ovf_set     = 1'b0;
        ret_ext     = RET_VALID ? {1'b0, RET_COUNT} : '0;
        sum         = {1'b0, credits_q} - {{width{1'b0}}, accept} + ret_ext;

        if (SETC) begin
            // A forced load discards any same-cycle return.
            if ({1'b0, DATA_C} > MAX_W) begin
                credits_nxt = MAX_C;
                ovf_set     = 1'b1;
            end else begin
                credits_nxt = DATA_C;
            end
        end else if (sum > MAX_W) begin
            credits_nxt = MAX_C;
            ovf_set     = 1'b1;
        end else begin
            credits_nxt = sum[width-1:0];
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: state registers use non-blocking assignments so every
        // register samples values from before this edge.
        if (RST) begin
            credits_q <= INIT_C;
            OUT_VALID <= 1'b0;
            OUT_DATA  <= '0;
            OVERFLOW  <= 1'b0;
        end else begin
            credits_q <= credits_nxt;
            OUT_VALID <= accept;
            if (accept) begin
                OUT_DATA <= IN_DATA;
            end
            // A new saturation outranks a same-cycle clear.
            if (ovf_set) begin
                OVERFLOW <= 1'b1;
            end else if (CLR_OVF) begin
                OVERFLOW <= 1'b0;
            end
        end
    end

endmodule

// File: doc/credit_tx_gate.md
Name: credit_tx_gate

Overview:
- Transmit-side credit gate: the sending end of a credit-flow link whose receiving end returns credits with a counter.
- Holds a credit counter. Lets upstream beats through only while credits are non-zero, and consumes one credit per forwarded beat.
- Credits are replenished by multi-credit returns from the far end.
- Sits between an upstream valid/ready source and a registered, credit-controlled downstream link with no ready signal.

Parameters:
- width, 4, credit counter width.
- dwidth, 8, data beat width.
- init_credits, 4, credit count loaded at reset; must be <= max_credits.
- max_credits, 15, credit ceiling; must be <= 2^width - 1.
- low_water, 1, LOW asserts when credits <= low_water.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  synchronous, active-high reset.
- IN_VALID  in  1  upstream beat offered.
- IN_DATA  in  dwidth  upstream beat data.
- IN_READY  out  1  gate can accept a beat this cycle.
- OUT_VALID  out  1  registered beat valid to the link.
- OUT_DATA  out  dwidth  registered beat data to the link.
- RET_VALID  in  1  credit return strobe.
- RET_COUNT  in  width  number of credits returned; 0 is legal.
- SETC  in  1  force the credit count.
- DATA_C  in  width  value for SETC.
- CLR_OVF  in  1  clear the sticky overflow flag.
- CREDITS  out  width  current credit count.
- LOW  out  1  credits <= low_water.
- OVERFLOW  out  1  sticky: a return would have exceeded max_credits.

Behaviour:
- Interface: one clock, CLK. Reset RST is synchronous and active-high, sampled on the CLK posedge.
- Reset values: CREDITS = init_credits, OUT_VALID = 0, OUT_DATA = 0, OVERFLOW = 0. LOW follows from CREDITS.
- IN_READY = !RST && !SETC && (CREDITS != 0). It is combinational from state, RST and SETC, and never depends on IN_VALID.
- accept = IN_VALID && IN_READY.
- Output register, latency 1:
  - OUT_VALID <= accept.
  - OUT_DATA <= IN_DATA on accept; otherwise OUT_DATA holds its last value.
  - OUT_VALID is high for exactly one cycle per accepted beat. Back-to-back accepts give consecutive OUT_VALID cycles.
- Credit next-state, evaluated in width+1 bits, highest priority first:
  - RST: init_credits.
  - SETC: DATA_C, saturated to max_credits. If DATA_C > max_credits, load max_credits and set OVERFLOW. Any RET_VALID in the same cycle is discarded; SETC wins.
  - Otherwise: sum = CREDITS - accept + (RET_VALID ? RET_COUNT : 0).
    - If sum > max_credits, CREDITS <= max_credits and OVERFLOW <= 1.
    - Otherwise CREDITS <= sum.
- Simultaneous accept and return: both apply in the same cycle.
  - Example: CREDITS = 1, accept, RET_COUNT = 2 gives CREDITS = 2.
  - Saturation is checked after the decrement.
- Underflow cannot occur, because accept requires CREDITS != 0.
- A return arriving with CREDITS = 0 does not allow an accept in the same cycle. IN_READY rises the following cycle.
- OVERFLOW:
  - Set by saturation in either the return path or the SETC path; cleared by RST or CLR_OVF.
  - If set and clear happen in the same cycle, set wins.
- LOW = (CREDITS <= low_water). It is combinational from the register.
- Reset mid-operation:
  - A beat offered in the reset cycle is not accepted.
  - OUT_VALID is 0 the cycle after reset.
  - Any pending return is discarded.
- Data is forwarded unchanged, with no reordering or buffering beyond the single output register.

Test Plan:
- Reset with defaults, then IN_VALID held high for 6 cycles, no returns -> exactly 4 OUT_VALID pulses carrying beats 1-4. IN_READY = 0 from cycle 5; CREDITS = 0; LOW = 1.
- CREDITS = 0 with IN_VALID high, then RET_VALID with RET_COUNT = 3 -> IN_READY = 0 in the return cycle and 1 in the next. Three more beats pass, then the gate stalls again.
- CREDITS = 2 with a simultaneous accept and RET_COUNT = 1 -> CREDITS stays 2; OUT_VALID = 1 the next cycle with the accepted data.
- CREDITS = 14, no accept, RET_COUNT = 5 -> CREDITS = 15 and OVERFLOW = 1. OVERFLOW stays set until CLR_OVF, then reads 0. A CLR_OVF coinciding with a new saturation leaves OVERFLOW = 1.
- SETC with DATA_C = 7 while IN_VALID and RET_VALID (count 2) are high -> IN_READY = 0 in that cycle, CREDITS = 7 and no beat sent. SETC with DATA_C = 20 (width = 5 build) -> CREDITS = 15, OVERFLOW = 1.
- RST asserted mid-stream with IN_VALID high and CREDITS = 3 -> no accept in the reset cycle. Next cycle: OUT_VALID = 0, CREDITS = 4, OVERFLOW = 0, OUT_DATA = 0.
